lcd_timing_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 34 +++
 rtl/mod_counter.sv | 39 +++
 rtl/lcd_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Timing defaults, coordinate widths and sequencer states shared by the LCD
// raster generator and the text renderer that consumes its coordinates.
package lcd_pkg;

   localparam int H_SYNC_DEF    = 1;
   localparam int H_BACK_DEF    = 45;
   localparam int H_ACTIVE_DEF  = 800;
   localparam int H_FRONT_DEF   = 210;
   localparam int H_TOTAL_DEF   = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;

   localparam int V_SYNC_DEF    = 1;
   localparam int V_BACK_DEF    = 22;
   localparam int V_ACTIVE_DEF  = 480;
   localparam int V_FRONT_DEF   = 22;
   localparam int V_TOTAL_DEF   = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;

   localparam int GREST_CYC_DEF = 16;

   localparam int X_W           = 11;
   localparam int Y_W           = 10;
   localparam int FRAME_CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_PANEL_RST = 2'd1,
      ST_RUN       = 2'd2
   } lcd_state_e;

   // Width able to hold the value n itself, so "one past the end" bounds fit.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable. nxt_o is the value the counter takes on the
// coming edge; wrap_o flags an enabled step from N-1 back to 0.
module mod_counter #(
   parameter int N = 8,
   parameter int W = $clog2(N + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   output logic [W-1:0] nxt_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         at_last;

   always_comb begin
      at_last = (cnt_q == LAST);
      cnt_d   = cnt_q;
      if (en_i) begin
         cnt_d = at_last ? '0 : cnt_q + W'(1);
      end
   end

   assign nxt_o  = cnt_d;
   assign wrap_o = en_i & at_last;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Panel raster timing: pixel-clock divider, GREST power-up hold, H/V counters
// and registered sync / DEN / coordinate decode for the LCD panel.
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int H_ACTIVE  = H_ACTIVE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int V_ACTIVE  = V_ACTIVE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int GREST_CYC = GREST_CYC_DEF
) (
   input  logic                   CLK,
   input  logic                   RST,
   output logic                   NCLK,
   output logic                   GREST,
   output logic                   HD,
   output logic                   VD,
   output logic                   DEN,
   output logic [X_W-1:0]         X,
   output logic [Y_W-1:0]         Y,
   output logic                   LINE_START,
   output logic                   FRAME_START,
   output logic [FRAME_CNT_W-1:0] FRAME_CNT,
   output lcd_state_e             dbg_state_o
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);
   localparam int GW      = cnt_width(GREST_CYC);

   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_VIS_BEG  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_VIS_BEG  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [GW-1:0] G_LAST     = GW'(GREST_CYC - 1);

   lcd_state_e             state_q;
   logic                   phase_q;
   logic                   grest_q;
   logic [GW-1:0]          g_cnt_q;
   logic                   hd_q;
   logic                   vd_q;
   logic                   den_q;
   logic [X_W-1:0]         x_q;
   logic [Y_W-1:0]         y_q;
   logic                   ls_q;
   logic                   fs_q;
   logic [FRAME_CNT_W-1:0] fcnt_q;

   logic                   tick;
   logic [HW-1:0]          h_nxt;
   logic [VW-1:0]          v_nxt;
   logic                   h_wrap;
   logic                   v_wrap;

   logic                   hd_d;
   logic                   vd_d;
   logic                   h_vis;
   logic                   v_vis;
   logic                   den_d;
   logic [X_W-1:0]         x_d;
   logic [Y_W-1:0]         y_d;

   // A pixel tick is the CLK edge that drops NCLK, so everything the panel
   // samples settles a full CLK before the next NCLK rising edge.
   assign tick = (state_q == ST_RUN) && phase_q;

   mod_counter #(.N(H_TOTAL), .W(HW)) u_h_cnt (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (tick),
      .nxt_o  (h_nxt),
      .wrap_o (h_wrap)
   );

   mod_counter #(.N(V_TOTAL), .W(VW)) u_v_cnt (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (h_wrap),
      .nxt_o  (v_nxt),
      .wrap_o (v_wrap)
   );

   // Decode from the counts being loaded this edge so outputs move with them.
   always_comb begin
      hd_d  = (h_nxt >= H_SYNC_END);
      vd_d  = (v_nxt >= V_SYNC_END);
      h_vis = (h_nxt >= H_VIS_BEG) && (h_nxt < H_VIS_END);
      v_vis = (v_nxt >= V_VIS_BEG) && (v_nxt < V_VIS_END);
      den_d = h_vis && v_vis;
      x_d   = den_d ? X_W'(h_nxt - H_VIS_BEG) : '0;
      y_d   = v_vis ? Y_W'(v_nxt - V_VIS_BEG) : '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_RESET;
         phase_q <= 1'b0;
         grest_q <= 1'b0;
         g_cnt_q <= '0;
         hd_q    <= 1'b1;
         vd_q    <= 1'b1;
         den_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         ls_q <= 1'b0;
         fs_q <= 1'b0;
         case (state_q)
            ST_RESET, ST_PANEL_RST: begin
               if (g_cnt_q == G_LAST) begin
                  state_q <= ST_RUN;
                  grest_q <= 1'b1;
               end else begin
                  state_q <= ST_PANEL_RST;
                  g_cnt_q <= g_cnt_q + GW'(1);
               end
            end
            ST_RUN: begin
               phase_q <= ~phase_q;
            end
            default: begin
               state_q <= ST_RESET;
            end
         endcase
         if (tick) begin
            hd_q  <= hd_d;
            vd_q  <= vd_d;
            den_q <= den_d;
            x_q   <= x_d;
            y_q   <= y_d;
            ls_q  <= h_wrap;
            fs_q  <= v_wrap;
            if (v_wrap) begin
               fcnt_q <= fcnt_q + FRAME_CNT_W'(1);
            end
         end
      end
   end

   assign NCLK        = phase_q;
   assign GREST       = grest_q;
   assign HD          = hd_q;
   assign VD          = vd_q;
   assign DEN         = den_q;
   assign X           = x_q;
   assign Y           = y_q;
   assign LINE_START  = ls_q;
   assign FRAME_START = fs_q;
   assign FRAME_CNT   = fcnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunken raster (8 x 5 ticks) so full frames,
// a FRAME_CNT wrap and a mid-frame reset fit in a short run.
module tb_lcd_timing_gen;
   import lcd_pkg::*;

   localparam int HS = 1, HB = 2, HA = 3, HF = 2;
   localparam int VS = 1, VB = 1, VA = 2, VF = 1;
   localparam int GC = 16;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME_CLK = 2 * HT * VT;

   typedef struct {
      int nclk, grest, hd, vd, den, x, y, ls, fs, fc, st;
   } obs_t;

   logic                   CLK;
   logic                   RST;
   logic                   NCLK, GREST, HD, VD, DEN;
   logic [X_W-1:0]         X;
   logic [Y_W-1:0]         Y;
   logic                   LINE_START, FRAME_START;
   logic [FRAME_CNT_W-1:0] FRAME_CNT;
   lcd_state_e             dbg_state;

   int   tests     = 0;
   int   fails     = 0;
   int   since_rel = 0;
   bit   chk_en    = 0;
   obs_t cmp_e, cmp_a, o;

   lcd_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
      .GREST_CYC(GC)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .NCLK        (NCLK),
      .GREST       (GREST),
      .HD          (HD),
      .VD          (VD),
      .DEN         (DEN),
      .X           (X),
      .Y           (Y),
      .LINE_START  (LINE_START),
      .FRAME_START (FRAME_START),
      .FRAME_CNT   (FRAME_CNT),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset-relative cycle count ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) begin
      if (RST) since_rel <= 0;
      else     since_rel <= since_rel + 1;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, since_rel);
      end
   endtask

   function automatic obs_t sample();
      obs_t a;
      a.nclk  = int'(NCLK);
      a.grest = int'(GREST);
      a.hd    = int'(HD);
      a.vd    = int'(VD);
      a.den   = int'(DEN);
      a.x     = int'(X);
      a.y     = int'(Y);
      a.ls    = int'(LINE_START);
      a.fs    = int'(FRAME_START);
      a.fc    = int'(FRAME_CNT);
      a.st    = int'(dbg_state);
      return a;
   endfunction

   // Expected outputs n CLK edges after reset release, from raster arithmetic:
   // GREST rises at edge GC, ticks fall every second edge after it, and tick k
   // places the beam at position k mod (HT*VT) of the frame.
   function automatic obs_t model(input int n, input logic in_rst);
      obs_t e;
      int   m, k, p, h, v;
      bit   hv, vv;
      e.nclk = 0; e.grest = 0; e.hd = 1; e.vd = 1; e.den = 0;
      e.x = 0; e.y = 0; e.ls = 0; e.fs = 0; e.fc = 0;
      e.st = int'(ST_RESET);
      if (in_rst) return e;
      if (n > 0) e.st = (n < GC) ? int'(ST_PANEL_RST) : int'(ST_RUN);
      if (n >= GC) e.grest = 1;
      if (n > GC) begin
         m = n - GC;
         e.nclk = m % 2;
         k = m / 2;
         if (k > 0) begin
            p = k % (HT * VT);
            h = p % HT;
            v = p / HT;
            hv = (h >= HS + HB) && (h < HS + HB + HA);
            vv = (v >= VS + VB) && (v < VS + VB + VA);
            e.hd  = (h >= HS) ? 1 : 0;
            e.vd  = (v >= VS) ? 1 : 0;
            e.den = (hv && vv) ? 1 : 0;
            e.x   = (hv && vv) ? h - (HS + HB) : 0;
            e.y   = vv ? v - (VS + VB) : 0;
            e.ls  = (m % 2 == 0 && h == 0) ? 1 : 0;
            e.fs  = (m % 2 == 0 && p == 0) ? 1 : 0;
            e.fc  = (k / (HT * VT)) % 256;
         end
      end
      return e;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge CLK) begin
      if (chk_en) begin
         cmp_e = model(since_rel, RST);
         cmp_a = sample();
         chk("nclk",  cmp_a.nclk,  cmp_e.nclk);
         chk("grest", cmp_a.grest, cmp_e.grest);
         chk("hd",    cmp_a.hd,    cmp_e.hd);
         chk("vd",    cmp_a.vd,    cmp_e.vd);
         chk("den",   cmp_a.den,   cmp_e.den);
         chk("x",     cmp_a.x,     cmp_e.x);
         chk("y",     cmp_a.y,     cmp_e.y);
         chk("ls",    cmp_a.ls,    cmp_e.ls);
         chk("fs",    cmp_a.fs,    cmp_e.fs);
         chk("fc",    cmp_a.fc,    cmp_e.fc);
         chk("state", cmp_a.st,    cmp_e.st);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic at_edge(input int n);
      int budget;
      budget = 40000;
      while (since_rel != n && budget > 0) begin
         @(negedge CLK);
         budget--;
      end
      if (since_rel != n) chk("at_edge_timeout", since_rel, n);
   endtask

   function automatic int sig(input int which);
      obs_t a;
      a = sample();
      case (which)
         0:       return a.hd;
         1:       return a.vd;
         default: return a.fs;
      endcase
   endfunction

   task automatic wait_edge(input int which, input int lvl, output int t);
      int prev, cur, budget;
      bit found;
      budget = 400;
      found  = 0;
      prev   = sig(which);
      while (!found && budget > 0) begin
         @(negedge CLK);
         budget--;
         cur = sig(which);
         if (cur == lvl && prev != lvl) found = 1;
         prev = cur;
      end
      t = since_rel;
      if (!found) chk("edge_timeout", which, -1);
   endtask

   // Hand-computed points after release (h_vis = 3..5, v_vis = 2..3).
   task automatic pin_sequence();
      at_edge(15); o = sample(); chk("grest@15", o.grest, 0);
      at_edge(16); o = sample(); chk("grest@16", o.grest, 1); chk("nclk@16", o.nclk, 0);
      chk("state@16", o.st, int'(ST_RUN));
      at_edge(17); o = sample(); chk("nclk@17", o.nclk, 1); chk("hd@17", o.hd, 1); chk("vd@17", o.vd, 1);
      at_edge(18); o = sample(); chk("hd@18", o.hd, 1); chk("vd@18", o.vd, 0); chk("nclk@18", o.nclk, 0);
      at_edge(32); o = sample(); chk("ls@32", o.ls, 1); chk("fs@32", o.fs, 0); chk("hd@32", o.hd, 0);
      chk("vd@32", o.vd, 1);
      at_edge(33); o = sample(); chk("ls@33", o.ls, 0); chk("hd@33", o.hd, 0);
      at_edge(34); o = sample(); chk("hd@34", o.hd, 1);
      at_edge(54); o = sample(); chk("den@54", o.den, 1); chk("x@54", o.x, 0); chk("y@54", o.y, 0);
      at_edge(58); o = sample(); chk("den@58", o.den, 1); chk("x@58", o.x, 2);
      at_edge(72); o = sample(); chk("den@72", o.den, 1); chk("x@72", o.x, 1); chk("y@72", o.y, 1);
      at_edge(78); o = sample(); chk("den@78", o.den, 0); chk("x@78", o.x, 0); chk("y@78", o.y, 1);
      at_edge(96); o = sample(); chk("fs@96", o.fs, 1); chk("ls@96", o.ls, 1); chk("fc@96", o.fc, 1);
      chk("vd@96", o.vd, 0); chk("hd@96", o.hd, 0);
      at_edge(97); o = sample(); chk("fs@97", o.fs, 0); chk("fc@97", o.fc, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t1, t2, t3, den_cnt, ls_cnt, budget;
      RST = 1'b1;
      @(posedge CLK);
      chk_en = 1'b1;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      o = sample();
      chk("rst_grest", o.grest, 0); chk("rst_hd", o.hd, 1); chk("rst_vd", o.vd, 1);
      chk("rst_nclk", o.nclk, 0); chk("rst_den", o.den, 0); chk("rst_fc", o.fc, 0);
      chk("rst_state", o.st, int'(ST_RESET));
      @(posedge CLK);
      #1 RST = 1'b0;

      pin_sequence();

      wait_edge(0, 0, t1); wait_edge(0, 1, t2); wait_edge(0, 0, t3);
      chk("hd_low_width", t2 - t1, 2);
      chk("hd_period", t3 - t1, 2 * HT);
      wait_edge(1, 0, t1); wait_edge(1, 1, t2); wait_edge(1, 0, t3);
      chk("vd_low_width", t2 - t1, 2 * HT * VS);
      chk("vd_period", t3 - t1, FRAME_CLK);

      wait_edge(2, 1, t1);
      den_cnt = 0; ls_cnt = 0; budget = 200;
      forever begin
         @(negedge CLK);
         budget--;
         if (DEN) den_cnt++;
         if (LINE_START) ls_cnt++;
         if (FRAME_START || budget == 0) break;
      end
      chk("den_clk_per_frame", den_cnt, 2 * HA * VA);
      chk("lines_per_frame", ls_cnt, VT);

      at_edge(GC + FRAME_CLK * 255); o = sample(); chk("fc@255", o.fc, 255);
      at_edge(GC + FRAME_CLK * 256); o = sample(); chk("fc_wrap", o.fc, 0); chk("fs_wrap", o.fs, 1);

      at_edge(GC + FRAME_CLK * 256 + 58);
      o = sample(); chk("mid_den", o.den, 1); chk("mid_x", o.x, 2); chk("mid_y", o.y, 1);
      @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      o = sample();
      chk("mid_rst_grest", o.grest, 0); chk("mid_rst_hd", o.hd, 1); chk("mid_rst_vd", o.vd, 1);
      chk("mid_rst_den", o.den, 0); chk("mid_rst_x", o.x, 0); chk("mid_rst_y", o.y, 0);
      chk("mid_rst_fc", o.fc, 0); chk("mid_rst_nclk", o.nclk, 0);
      @(posedge CLK);
      #1 RST = 1'b0;

      pin_sequence();

      @(negedge CLK);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
